// File: rtl/apb_acc_master_if.sv
// Bundle of the command, write-stream, read-stream, status and APB signals
// between apb_acc_master (master modport) and its surroundings (slave modport).
interface apb_acc_master_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH      = 10
);
    // Every valid/ready pair transfers on a rising clock edge where both are
    // high; a producer never waits for ready before raising valid.
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [APB_ADDR_WIDTH-1:0] cmd_addr;
    logic [CNT_WIDTH-1:0]      cmd_len;

    logic                      wr_valid;
    logic                      wr_ready;
    logic [31:0]               wr_data;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [31:0]               rd_data;

    logic                      busy;
    logic                      done;
    logic                      done_err;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, done_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, done_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_acc_master.sv
// APB burst initiator: one APB transfer per word at consecutive word addresses.
// Define APB_MASTER_TIMEOUT_EN to abort a burst when PREADY stalls TIMEOUT_CYCLES.
module apb_acc_master #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          CNT_WIDTH      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESET,
    apb_acc_master_if.master    bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_WR = 3'd1,
        S_SETUP   = 3'd2,
        S_ACCESS  = 3'd3,
        S_RD_HOLD = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]      remaining_q;
    logic                      write_q;
    logic                      err_q;
    logic [31:0]               pwdata_q;
    logic [31:0]               rd_data_q;
    logic                      timeout;
    logic                      unused_cfg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (bus.cmd_write) begin
                        state_d = S_WAIT_WR;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_WAIT_WR: begin
                if (bus.wr_valid) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // remaining_q still counts the beat completing this cycle.
                if (bus.PREADY) begin
                    if (!write_q) begin
                        state_d = S_RD_HOLD;
                    end else if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_WR;
                    end
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_RD_HOLD: begin
                if (bus.rd_ready) begin
                    state_d = (remaining_q == '0) ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.done      = 1'b0;
        bus.done_err  = 1'b0;
        unique case (state_q)
            S_IDLE:    bus.cmd_ready = 1'b1;
            S_WAIT_WR: bus.wr_ready  = 1'b1;
            S_SETUP:   bus.PSEL      = 1'b1;
            S_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
            end
            S_RD_HOLD: bus.rd_valid  = 1'b1;
            S_DONE: begin
                bus.done     = 1'b1;
                bus.done_err = err_q;
            end
            default: ;
        endcase
        bus.busy = (state_q != S_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q      <= '0;
            remaining_q <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            pwdata_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q      <= {bus.cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                        remaining_q <= bus.cmd_len;
                        write_q     <= bus.cmd_write;
                        err_q       <= 1'b0;
                    end
                end
                S_WAIT_WR: begin
                    if (bus.wr_valid) begin
                        pwdata_q <= bus.wr_data;
                    end
                end
                S_ACCESS: begin
                    // The address advances only after the beat, so PADDR is
                    // stable across SETUP and all of ACCESS; it wraps naturally.
                    if (bus.PREADY) begin
                        err_q       <= err_q | bus.PSLVERR;
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        addr_q      <= addr_q + APB_ADDR_WIDTH'(4);
                        if (!write_q) begin
                            rd_data_q <= bus.PRDATA;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counts stalled ACCESS cycles of the current beat; SETUP restarts it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            to_cnt_q <= '0;
        end else if ((state_q == S_ACCESS) && !bus.PREADY) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout    = (state_q == S_ACCESS) && !bus.PREADY &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign unused_cfg = ^bus.cmd_addr[1:0];
`else
    assign timeout    = 1'b0;
    assign unused_cfg = ^{bus.cmd_addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

    assign bus.PADDR   = addr_q;
    assign bus.PWRITE  = write_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.rd_data = rd_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_acc_master.sv
// Scoreboard bench for apb_acc_master: stimulus queues expected APB beats, read
// words and done status; a negedge monitor pops and compares them.
module tb_apb_acc_master;
  localparam int AW = 12;
  localparam int CW = 10;
  localparam int TO = 8;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [2:0] dbg_state;

  apb_acc_master_if #(.APB_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  apb_acc_master #(
    .APB_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [31:0]   wdata;
    int            waits;
  } apb_exp_t;

  typedef struct {
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
  } beat_t;

  apb_exp_t    exp_apb_q[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_done_q[$];
  beat_t       beat_q[$];
  logic [31:0] wr_src_q[$];

  int checks = 0;
  int errors = 0;
  int rd_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic flush_all();
    exp_apb_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    beat_q.delete();
    wr_src_q.delete();
  endtask

  // reference model: expected beats computed from base + 4*i modulo window
  task automatic queue_cmd(input logic wr, input logic [AW-1:0] addr, input int len,
                           input int mode, input int min_wait, input int max_wait,
                           input int err_pct);
    logic err = 1'b0;
    for (int i = 0; i < len; i++) begin
      beat_t    b;
      apb_exp_t e;
      logic [31:0] word;
      int a;
      a = ((int'(addr) & ~3) + 4 * i) % (1 << AW);
      if (mode == 1)      word = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      else if (mode == 2) word = {16'(2*i+1), 16'(2*i)};
      else                word = $urandom;
      b.waits  = $urandom_range(min_wait, max_wait);
      b.slverr = ($urandom_range(0, 99) < err_pct);
      b.rdata  = word;
      e.addr   = a[AW-1:0];
      e.wr     = wr;
      e.wdata  = word;
      e.waits  = b.waits;
      beat_q.push_back(b);
      exp_apb_q.push_back(e);
      if (wr) wr_src_q.push_back(word);
      else    exp_rd_q.push_back(word);
      err |= b.slverr;
    end
    exp_done_q.push_back(err);
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr, input int len);
    int n = 0;
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = CW'(len);
    do begin
      @(negedge HCLK);
      n++;
    end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) fail_event("cmd_accept_timeout");
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = CW'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (exp_done_q.size() != 0 && n < limit) begin
      @(negedge HCLK);
      n++;
    end
    if (exp_done_q.size() != 0) begin
      fail_event("done_timeout");
      flush_all();
    end
    repeat ($urandom_range(1, 3)) @(negedge HCLK);
  endtask

  // write stream driver
  initial begin
    logic hs;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(negedge HCLK);
      hs = bus.wr_valid && bus.wr_ready;
      @(posedge HCLK); #1;
      if (hs && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
      if (wr_src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wr_src_q[0];
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = $urandom;
      end
    end
  end

  // read stream sink
  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge HCLK); #1;
      if (rd_stall > 0) begin
        bus.rd_ready = 1'b0;
        if (bus.rd_valid) rd_stall--;
      end else begin
        bus.rd_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // APB slave driver
  initial begin
    beat_t cur;
    int    cnt = 0;
    logic  in_beat = 1'b0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    forever begin
      @(posedge HCLK); #1;
      if (bus.PSEL && bus.PENABLE) begin
        if (!in_beat) begin
          if (beat_q.size() > 0) cur = beat_q.pop_front();
          else cur = '{waits: 0, slverr: 1'b0, rdata: 32'hDEAD_BEEF};
          cnt = cur.waits;
          in_beat = 1'b1;
        end
        if (cnt == 0) begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = cur.slverr;
          bus.PRDATA  = cur.rdata;
          in_beat = 1'b0;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'($urandom);
          bus.PRDATA  = $urandom;
          cnt--;
        end
      end else begin
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
        in_beat = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic          prev_setup = 1'b0;
    logic          prev_apb = 1'b0;
    logic          prev_rd_stall = 1'b0;
    logic [AW-1:0] prev_paddr = '0;
    logic          prev_pwrite = 1'b0;
    logic [31:0]   prev_pwdata = '0;
    logic [31:0]   prev_rd_data = '0;
    int            acc_cycles = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        prev_setup = 1'b0;
        prev_apb = 1'b0;
        prev_rd_stall = 1'b0;
        acc_cycles = 0;
      end else begin
        if (bus.PSEL && bus.PENABLE) begin
          if (acc_cycles == 0) check("setup_before_access", prev_setup, 1);
          if (prev_apb) begin
            check("paddr_stable", bus.PADDR, prev_paddr);
            check("pwrite_stable", bus.PWRITE, prev_pwrite);
            check("pwdata_stable", bus.PWDATA, prev_pwdata);
          end
          acc_cycles++;
          if (bus.PREADY) begin
            if (exp_apb_q.size() == 0) begin
              fail_event("apb_unexpected");
            end else begin
              apb_exp_t e;
              e = exp_apb_q.pop_front();
              check("paddr", bus.PADDR, e.addr);
              check("pwrite", bus.PWRITE, e.wr);
              if (e.wr) check("pwdata", bus.PWDATA, e.wdata);
              check("access_cycles", acc_cycles, e.waits + 1);
            end
            acc_cycles = 0;
          end
        end else begin
          acc_cycles = 0;
        end
        if (bus.rd_valid) check("no_psel_in_rd_hold", bus.PSEL, 0);
        if (prev_rd_stall) begin
          check("rd_valid_held", bus.rd_valid, 1);
          check("rd_data_held", bus.rd_data, prev_rd_data);
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_rd_q.size() == 0) fail_event("rd_unexpected");
          else check("rd_data", bus.rd_data, exp_rd_q.pop_front());
        end
        if (bus.done) begin
          if (exp_done_q.size() == 0) fail_event("done_unexpected");
          else check("done_err", bus.done_err, exp_done_q.pop_front());
        end
        prev_setup    = bus.PSEL && !bus.PENABLE;
        prev_apb      = bus.PSEL;
        prev_paddr    = bus.PADDR;
        prev_pwrite   = bus.PWRITE;
        prev_pwdata   = bus.PWDATA;
        prev_rd_stall = bus.rd_valid && !bus.rd_ready;
        prev_rd_data  = bus.rd_data;
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_paddr", bus.PADDR, 0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // byte-ramp write burst
    queue_cmd(1'b1, 12'h004, 4, 1, 0, 0, 0);
    drive_cmd(1'b1, 12'h004, 4);
    wait_done(500);

    // halfword-ramp read burst with a stalled consumer
    queue_cmd(1'b0, 12'h004, 2, 2, 0, 0, 0);
    rd_stall = 5;
    drive_cmd(1'b0, 12'h004, 2);
    wait_done(500);

    // single stalled write with slave error
    queue_cmd(1'b1, 12'h020, 1, 0, 3, 3, 100);
    drive_cmd(1'b1, 12'h020, 1);
    wait_done(500);

    // address wrap, with unaligned low bits
    queue_cmd(1'b0, 12'hFFE, 2, 0, 0, 1, 0);
    drive_cmd(1'b0, 12'hFFE, 2);
    wait_done(500);

    // zero-length command
    queue_cmd(1'b1, 12'h100, 0, 0, 0, 0, 0);
    drive_cmd(1'b1, 12'h100, 0);
    @(negedge HCLK);
    check("len0_done", bus.done, 1);
    check("len0_psel", bus.PSEL, 0);
    wait_done(50);

    // reset during ACCESS of the second of four words
    queue_cmd(1'b1, 12'h200, 4, 0, 0, 0, 0);
    drive_cmd(1'b1, 12'h200, 4);
    n = 0;
    while (!(bus.PSEL && bus.PENABLE && bus.PADDR == 12'h204) && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    check("reach_word2_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_psel", bus.PSEL, 0);
    check("midrst_penable", bus.PENABLE, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_done", bus.done, 0);
    flush_all();
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);
    queue_cmd(1'b1, 12'h300, 3, 0, 0, 2, 20);
    drive_cmd(1'b1, 12'h300, 3);
    wait_done(500);

    // randomized bursts
    for (int k = 0; k < 30; k++) begin
      logic          wr;
      logic [AW-1:0] addr;
      int            len;
      wr   = 1'($urandom);
      addr = AW'($urandom);
      len  = $urandom_range(0, 6);
      queue_cmd(wr, addr, len, 0, 0, 3, 15);
      drive_cmd(wr, addr, len);
      wait_done(1000);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int   acc = 0;
      logic rd_seen = 1'b0;
      beat_t b;
      b.waits  = 1000;
      b.slverr = 1'b0;
      b.rdata  = $urandom;
      beat_q.push_back(b);
      exp_done_q.push_back(1'b1);
      drive_cmd(1'b0, 12'h040, 3);
      n = 0;
      while (!bus.done && n < 200) begin
        @(negedge HCLK);
        if (bus.PSEL && bus.PENABLE) acc++;
        if (bus.rd_valid) rd_seen = 1'b1;
        n++;
      end
      check("timeout_access_cycles", acc, TO);
      check("timeout_no_rd_valid", rd_seen, 0);
      wait_done(50);
      beat_q.delete();
    end
`endif

    repeat (5) @(negedge HCLK);
    check("leftover_apb", exp_apb_q.size(), 0);
    check("leftover_rd", exp_rd_q.size(), 0);
    check("leftover_wr", wr_src_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
